// File: rtl/vga_rect_filler.sv
// vga_rect_filler
//   Drawing engine that sits on the user side of the VGA adapter's pixel-write
//   port. A start request fills an axis-aligned rectangle, or the whole screen
//   in clear mode, with one color. Pixels are emitted one per clock in raster
//   order, and a hold input pauses the stream without skipping or repeating
//   any pixel.
//
// Ports
//   clock       system clock (shared with the adapter's write port)
//   resetn      synchronous active-low reset
//   start       fill request, sampled only while idle
//   clear       with start: fill the full screen, ignore the corner inputs
//   x0, y0      first corner
//   x1, y1      second corner
//   fill_color  fill color, latched when the request is accepted
//   hold        pause: suppresses write and freezes the position
//   x, y        pixel coordinate to the adapter (registered)
//   color       pixel color to the adapter (registered)
//   write       pixel write strobe to the adapter (combinational)
//   busy        high while filling
//   done        one-cycle completion pulse
module vga_rect_filler #(
    parameter int COLOR_DEPTH = 9,
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLS        = 640,
    parameter int ROWS        = 480
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   clear,
    input  logic [nX-1:0]          x0,
    input  logic [nY-1:0]          y0,
    input  logic [nX-1:0]          x1,
    input  logic [nY-1:0]          y1,
    input  logic [COLOR_DEPTH-1:0] fill_color,
    input  logic                   hold,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    localparam logic [nX-1:0] X_LAST = nX'(COLS - 1);
    localparam logic [nY-1:0] Y_LAST = nY'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state, state_next;

    // Latched bounds. ymin is never needed after the load: rows only advance.
    logic [nX-1:0]          xmin, xmax;
    logic [nY-1:0]          ymax;
    logic [nX-1:0]          xmin_next, xmax_next, x_next;
    logic [nY-1:0]          ymax_next, y_next;
    logic [COLOR_DEPTH-1:0] color_next;

    // Normalised and clipped request bounds
    logic [nX-1:0] req_xmin, req_xmax;
    logic [nY-1:0] req_ymin, req_ymax;
    logic          req_empty;

    always_comb begin
        req_xmin = clear ? '0     : ((x0 < x1) ? x0 : x1);
        req_xmax = clear ? X_LAST : ((x0 < x1) ? x1 : x0);
        req_ymin = clear ? '0     : ((y0 < y1) ? y0 : y1);
        req_ymax = clear ? Y_LAST : ((y0 < y1) ? y1 : y0);
        // A rectangle starting off-screen draws nothing; otherwise clip the far edge.
        req_empty = (req_xmin > X_LAST) || (req_ymin > Y_LAST);
        if (req_xmax > X_LAST) req_xmax = X_LAST;
        if (req_ymax > Y_LAST) req_ymax = Y_LAST;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            color <= '0;
            xmin  <= '0;
            xmax  <= '0;
            ymax  <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
            color <= color_next;
            xmin  <= xmin_next;
            xmax  <= xmax_next;
            ymax  <= ymax_next;
        end
    end

    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        color_next = color;
        xmin_next  = xmin;
        xmax_next  = xmax;
        ymax_next  = ymax;
        write      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (req_empty) begin
                        state_next = DONE;
                    end else begin
                        state_next = FILL;
                        xmin_next  = req_xmin;
                        xmax_next  = req_xmax;
                        ymax_next  = req_ymax;
                        x_next     = req_xmin;
                        y_next     = req_ymin;
                        color_next = fill_color;
                    end
                end
            end

            FILL: begin
                busy  = 1'b1;
                write = ~hold;
                if (!hold) begin
                    if (x < xmax) begin
                        x_next = x + 1'b1;
                    end else if (y < ymax) begin
                        x_next = xmin;
                        y_next = y + 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Testbench for vga_rect_filler. The DUT runs at a reduced 80x60 screen so a
// full clear stays short; the reference model builds the expected pixel list
// directly from the rectangle rules and the bench consumes it write by write.
module tb_vga_rect_filler;

    localparam int TC = 80;
    localparam int TR = 60;

    logic       clock = 1'b0;
    logic       resetn, start, clear, hold;
    logic [9:0] x0, x1, x;
    logic [8:0] y0, y1, y;
    logic [8:0] fill_color, color;
    logic       write, busy, done;

    int checks   = 0;
    int failures = 0;
    int last_x   = 0;
    int last_y   = 0;

    always #5 clock = ~clock;

    vga_rect_filler #(
        .COLOR_DEPTH(9),
        .nX(10),
        .nY(9),
        .COLS(TC),
        .ROWS(TR)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .clear(clear),
        .x0(x0),
        .y0(y0),
        .x1(x1),
        .y1(y1),
        .fill_color(fill_color),
        .hold(hold),
        .x(x),
        .y(y),
        .color(color),
        .write(write),
        .busy(busy),
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to the end of the done pulse.
    // hold_at >= 0 pauses for 3 cycles when the pixel with that index is next.
    task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit aclr, input int acol, input int hold_at,
                            input bit hold_rand);
        int qx[$];
        int qy[$];
        int xmn, xmx, ymn, ymx;
        int guard, idx, hold_left;
        logic [9:0] cx;
        logic [8:0] cy, cc;

        xmn = aclr ? 0      : ((ax0 < ax1) ? ax0 : ax1);
        xmx = aclr ? TC - 1 : ((ax0 < ax1) ? ax1 : ax0);
        ymn = aclr ? 0      : ((ay0 < ay1) ? ay0 : ay1);
        ymx = aclr ? TR - 1 : ((ay0 < ay1) ? ay1 : ay0);
        if (xmn < TC && ymn < TR) begin
            if (xmx > TC - 1) xmx = TC - 1;
            if (ymx > TR - 1) ymx = TR - 1;
            for (int yy = ymn; yy <= ymx; yy++)
                for (int xx = xmn; xx <= xmx; xx++) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        end

        cx = 10'(ax0); x0 = cx;
        cx = 10'(ax1); x1 = cx;
        cy = 9'(ay0);  y0 = cy;
        cy = 9'(ay1);  y1 = cy;
        cc = 9'(acol); fill_color = cc;
        clear = aclr;
        hold  = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        clear = 1'b0;

        guard     = 4 * qx.size() + 20;
        idx       = 0;
        hold_left = (hold_at >= 0) ? 3 : 0;
        while (qx.size() > 0 && guard > 0) begin
            guard--;
            if (idx == hold_at && hold_left > 0) begin
                hold = 1'b1;
                hold_left--;
            end else if (hold_rand) begin
                hold = ($urandom_range(0, 3) == 0);
            end else begin
                hold = 1'b0;
            end
            // Stray requests during the fill must be ignored.
            start = ($urandom_range(0, 7) == 0);
            x0 = 10'($urandom_range(0, 79));
            y0 = 9'($urandom_range(0, 59));
            #1;
            check("busy_fill", 32'(busy), 1);
            check("done_fill", 32'(done), 0);
            check("write_fill", 32'(write), 32'(!hold));
            if (!hold) begin
                check("pix_x", 32'(x), qx[0]);
                check("pix_y", 32'(y), qy[0]);
                check("pix_color", 32'(color), acol);
                last_x = qx.pop_front();
                last_y = qy.pop_front();
                idx++;
            end
            @(negedge clock);
        end
        hold  = 1'b0;
        start = 1'b0;
        #1;
        check("pixels_left", qx.size(), 0);
        check("done_pulse", 32'(done), 1);
        check("busy_done", 32'(busy), 0);
        check("write_done", 32'(write), 0);
        check("last_x", 32'(x), last_x);
        check("last_y", 32'(y), last_y);
        @(negedge clock);
        #1;
        check("done_idle", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check("write_idle", 32'(write), 0);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;

        resetn = 1'b0; start = 1'b0; clear = 1'b0; hold = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; fill_color = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_color", 32'(color), 0);
        check("rst_write", 32'(write), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        // Basic rectangle, swapped corners, single pixel
        run_fill(2, 5, 4, 6, 1'b0, 9'h1C0, -1, 1'b0);
        run_fill(4, 6, 2, 5, 1'b0, 9'h1C0, -1, 1'b0);
        run_fill(7, 7, 7, 7, 1'b0, 9'h055, -1, 1'b0);

        // Clipping at the far edges; start beyond the screen draws nothing
        run_fill(TC - 10, TR - 10, 1000, 500, 1'b0, 9'h0AA, -1, 1'b0);
        run_fill(TC + 20, 10, TC + 120, 20, 1'b0, 9'h123, -1, 1'b0);
        run_fill(TC, 0, TC, 0, 1'b0, 9'h123, -1, 1'b0);
        run_fill(0, TR, 5, TR + 3, 1'b0, 9'h123, -1, 1'b0);
        run_fill(TC - 1, TR - 1, TC - 1, TR - 1, 1'b0, 9'h1FF, -1, 1'b0);

        // Hold for 3 cycles while (1,0) is the next pixel
        run_fill(0, 0, 3, 0, 1'b0, 9'h0F0, 1, 1'b0);

        // Full-screen clear ignores the corners
        run_fill(33, 44, 12, 7, 1'b1, 9'h000, -1, 1'b1);

        // Randomised rectangles with random hold
        for (int n = 0; n < 12; n++) begin
            rx0 = $urandom_range(0, TC + 15);
            ry0 = $urandom_range(0, TR + 10);
            rx1 = $urandom_range((rx0 > 6) ? rx0 - 6 : 0, rx0 + 6);
            ry1 = $urandom_range((ry0 > 5) ? ry0 - 5 : 0, ry0 + 5);
            run_fill(rx0, ry0, rx1, ry1, 1'b0, $urandom_range(0, 511), -1, 1'b1);
        end

        // Reset in the middle of a fill
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd9; y1 = 9'd9; fill_color = 9'h1AB;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("midrst_write", 32'(write), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_x", 32'(x), 0);
        check("midrst_y", 32'(y), 0);
        last_x = 0;
        last_y = 0;
        @(negedge clock);
        #1;
        check("midrst_idle_write", 32'(write), 0);
        run_fill(0, 0, 1, 0, 1'b0, 9'h011, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_rect_filler.md
Name: vga_rect_filler

Overview:
- Drawing engine on the user side of the VGA adapter's pixel-write interface. It drives the adapter's x, y, color and write ports.
- On a start request it fills an axis-aligned rectangle, or the whole screen in clear mode, with one color. It emits one pixel write per clock in raster order.
- It provides a busy/done handshake toward the controlling FSM and a hold input to pause the pixel stream.

Parameters:
- COLOR_DEPTH, 9, bits per pixel color.
- nX, 10, x coordinate width.
- nY, 9, y coordinate width.
- COLS, 640, visible columns.
- ROWS, 480, visible rows.

Ports:
- clock  input  1  system clock, same 50 MHz clock as the adapter's write port.
- resetn  input  1  synchronous active-low reset.
- start  input  1  request a fill; sampled only in IDLE.
- clear  input  1  with start: fill the full screen, ignoring corner inputs.
- x0  input  nX  first corner x.
- y0  input  nY  first corner y.
- x1  input  nX  second corner x.
- y1  input  nY  second corner y.
- fill_color  input  COLOR_DEPTH  fill color, latched at start.
- hold  input  1  pause; suppresses write and freezes position.
- x  output  nX  pixel x, to adapter.
- y  output  nY  pixel y, to adapter.
- color  output  COLOR_DEPTH  pixel color, to adapter.
- write  output  1  pixel write strobe, to adapter.
- busy  output  1  high while filling.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface fact: one clock; reset is synchronous and active-low, named clock and resetn.
- States:
  - IDLE, FILL, DONE.
  - Reset (resetn low at an edge) forces IDLE with x=0, y=0, color=0, latched bounds=0.
  - In IDLE: write=0, busy=0, done=0.
  - Reset mid-FILL takes effect at that edge. No further writes; write is low from the next cycle.
- Start acceptance (IDLE, start=1 at edge k):
  - Normalise bounds: xmin=min(x0,x1), xmax=max(x0,x1); same for y.
  - If clear=1: xmin=0, xmax=COLS-1, ymin=0, ymax=ROWS-1.
  - Clip: if xmin>=COLS or ymin>=ROWS, nothing is drawn and the state goes to DONE at edge k.
  - Otherwise xmax=min(xmax,COLS-1) and ymax=min(ymax,ROWS-1). Latch the bounds and fill_color into color, load x=xmin, y=ymin, and go to FILL at edge k.
- FILL:
  - busy=1.
  - write is combinational: write = (state==FILL) & ~hold. x, y and color are registered.
  - At each edge where write=1:
    - If x<xmax: x increments.
    - Else if y<ymax: x=xmin and y increments.
    - Else (x=xmax, y=ymax): go to DONE.
  - At an edge where hold=1: x, y and state are unchanged, so no pixel is skipped or duplicated.
- Counts:
  - write is high for exactly (xmax-xmin+1)*(ymax-ymin+1) cycles, excluding hold cycles.
  - First write is in the cycle after edge k; latency from start is 1 cycle.
- DONE:
  - done=1, busy=0, write=0 for exactly one cycle, then IDLE.
  - start is ignored in FILL and DONE; it has no effect and is not queued.
- Width rules:
  - Comparisons are unsigned at nX/nY width.
  - The x increment never exceeds xmax, so there is no coordinate wrap.
  - The full-screen clear issues 307200 writes at the defaults.
- Outputs hold their last values in IDLE/DONE; x and y remain at the last pixel drawn.

Test Plan:
- Basic rectangle: start, x0=2, y0=5, x1=4, y1=6, fill_color=9'h1C0 → 6 consecutive write cycles at (2,5),(3,5),(4,5),(2,6),(3,6),(4,6), all with color 1C0. Then done=1 for 1 cycle, busy falls with done.
- Corner ordering and single pixel:
  - Corners swapped (4,6)-(2,5) → identical 6-pixel sequence.
  - (7,7)-(7,7) → exactly 1 write at (7,7), then done.
- Clipping:
  - (630,470)-(1000,500) → 100 writes covering x 630..639, y 470..479; last write at (639,479).
  - (700,10)-(800,20) → zero writes; done asserted the cycle after start.
- Clear mode: clear=1, start, fill_color=0 → 307200 write cycles; first (0,0), last (639,479); then a done pulse. A start pulsed mid-fill is ignored, with no restart.
- Hold: fill (0,0)-(3,0) with hold=1 for 3 cycles while at (1,0) → write low for 3 cycles, then (1,0),(2,0),(3,0) resume. Exactly 4 writes total, none duplicated.
- Reset mid-fill: resetn low one edge during the fill of (0,0)-(9,9) → next cycle write=0, busy=0, done=0, x=y=0. A new start for (0,0)-(1,0) then yields 2 writes and done.
